// File: rtl/dct_stream_pkg.sv
// Shared geometry and row-stream types for the DCT input path.
// Word/lane/block sizes live here so the reader, its interface and the bench agree.
package dct_stream_pkg;

  localparam int DCT_FIFO_WIDTH     = 256;
  localparam int DCT_LANE_WIDTH     = 64;
  localparam int DCT_ROWS_PER_BLOCK = 8;
  localparam int DCT_LANES          = DCT_FIFO_WIDTH / DCT_LANE_WIDTH;
  localparam int DCT_ROW_W          = (DCT_ROWS_PER_BLOCK > 1) ? $clog2(DCT_ROWS_PER_BLOCK) : 1;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [DCT_LANE_WIDTH-1:0] data;
    logic [DCT_ROW_W-1:0]      row;
    logic                      first;
    logic                      last;
  } dct_row_t;

endpackage

// File: rtl/fifo_row_reader_if.sv
// FIFO drain port plus the tagged row stream toward the row-DCT stage.
// master = the row reader, slave = FIFO/downstream side.
interface fifo_row_reader_if
  import dct_stream_pkg::*;
#(
  parameter int FIFO_WIDTH     = DCT_FIFO_WIDTH,
  parameter int LANE_WIDTH     = DCT_LANE_WIDTH,
  parameter int ROWS_PER_BLOCK = DCT_ROWS_PER_BLOCK
);

  localparam int ROW_W = idx_w(ROWS_PER_BLOCK);

  logic                  fifo_read;
  logic [FIFO_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;

  logic [LANE_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ROW_W-1:0]      out_row;
  logic                  out_first;
  logic                  out_last;

  modport master (
    output fifo_read,
    input  fifo_data,
    input  fifo_empty,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_row,
    output out_first,
    output out_last
  );

  modport slave (
    input  fifo_read,
    output fifo_data,
    output fifo_empty,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_row,
    input  out_first,
    input  out_last
  );

endinterface

// File: rtl/word_skid_buffer.sv
// Two-entry word buffer that absorbs the FIFO's registered read latency.
// Storage is deliberately left unreset; only pointers and occupancy are cleared.
module word_skid_buffer
  import dct_stream_pkg::*;
#(
  parameter int WIDTH = DCT_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop   = pop_i && (occ_q != 2'd0);
    do_push  = push_i && !clr_i && ((occ_q != 2'd2) || do_pop);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    occ_d    = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    if (clr_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_row_reader.sv
// Drains 256-bit FIFO words and emits them as 64-bit rows, lane 0 first,
// tagged with the row index and first/last markers of each 8x8 block.
module fifo_row_reader
  import dct_stream_pkg::*;
#(
  parameter int FIFO_WIDTH     = DCT_FIFO_WIDTH,
  parameter int LANE_WIDTH     = DCT_LANE_WIDTH,
  parameter int ROWS_PER_BLOCK = DCT_ROWS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              busy,
  fifo_row_reader_if.master bus
);

  localparam int LANES  = FIFO_WIDTH / LANE_WIDTH;
  localparam int LANE_W = idx_w(LANES);
  localparam int ROW_W  = idx_w(ROWS_PER_BLOCK);

  if ((FIFO_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
    $error("fifo_row_reader: FIFO_WIDTH must be a multiple of LANE_WIDTH");
  end
  if ((ROWS_PER_BLOCK % LANES) != 0) begin : g_bad_block_rows
    $error("fifo_row_reader: ROWS_PER_BLOCK must be a multiple of LANES");
  end

  logic [1:0]            occ;
  logic [FIFO_WIDTH-1:0] head;
  logic [LANE_WIDTH-1:0] lane_word [LANES];

  logic              pending_q, pending_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic       fire;
  logic       lane_last;
  logic       row_last;
  logic       pop;
  logic [2:0] level;

  word_skid_buffer #(
    .WIDTH (FIFO_WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush),
    .push_i (pending_q),
    .data_i (bus.fifo_data),
    .pop_i  (pop),
    .head_o (head),
    .occ_o  (occ)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_word[g] = head[g*LANE_WIDTH +: LANE_WIDTH];
  end

  // Issue a read only if the buffer can still hold the returning word after
  // this cycle's pop, counting the word already in flight.
  always_comb begin
    fire          = bus.out_valid && bus.out_ready;
    lane_last     = (lane_q == LANE_W'(LANES - 1));
    row_last      = (row_q == ROW_W'(ROWS_PER_BLOCK - 1));
    pop           = fire && lane_last;
    level         = 3'(occ) + 3'(pending_q) - 3'(pop);
    bus.fifo_read = rst && !flush && !bus.fifo_empty && (level < 3'd2);
  end

  always_comb begin
    lane_d    = lane_q;
    row_d     = row_q;
    pending_d = bus.fifo_read;
    if (flush) begin
      lane_d    = '0;
      row_d     = '0;
      pending_d = 1'b0;
    end else if (fire) begin
      lane_d = lane_last ? '0 : lane_q + 1'b1;
      row_d  = row_last  ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      lane_q    <= '0;
      row_q     <= '0;
    end else begin
      pending_q <= pending_d;
      lane_q    <= lane_d;
      row_q     <= row_d;
    end
  end

  always_comb begin
    bus.out_valid = (occ != 2'd0);
    bus.out_data  = lane_word[lane_q];
    bus.out_row   = row_q;
    bus.out_first = (row_q == '0);
    bus.out_last  = row_last;
    busy          = (occ != 2'd0) || pending_q;
  end

endmodule
